// File: rtl/sram_fifo_arbiter_if.sv
// Handshake and FIFO-side bundle for the SRAM FIFO arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the FIFO.
interface sram_fifo_arbiter_if #(
    parameter int BITS  = 8,
    parameter int CNT_W = 4
);
    logic             wr0_valid;
    logic [BITS-1:0]  wr0_data;
    logic             wr0_ready;
    logic             wr1_valid;
    logic [BITS-1:0]  wr1_data;
    logic             wr1_ready;
    logic             rd_req;
    logic             rd_ack;
    logic             rd_valid;
    logic [BITS-1:0]  rd_data;
    logic             fifo_rd;
    logic             fifo_wr;
    logic [BITS-1:0]  fifo_wdata;
    logic [BITS-1:0]  fifo_rdata;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport slave (
        input  wr0_valid, wr0_data, wr1_valid, wr1_data, rd_req, fifo_rdata,
        output wr0_ready, wr1_ready, rd_ack, rd_valid, rd_data,
               fifo_rd, fifo_wr, fifo_wdata, count, full, empty
    );

    modport master (
        output wr0_valid, wr0_data, wr1_valid, wr1_data, rd_req, fifo_rdata,
        input  wr0_ready, wr1_ready, rd_ack, rd_valid, rd_data,
               fifo_rd, fifo_wr, fifo_wdata, count, full, empty
    );
endinterface

// File: rtl/sram_fifo_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM FIFO between two writers and one reader.
// It tracks occupancy so that the unprotected FIFO never receives a write when full or a read when empty.
module sram_fifo_arbiter #(
    parameter int BITS   = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4,
    parameter int RD_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    sram_fifo_arbiter_if.slave bus
);
    typedef enum logic [1:0] {SRC_W0, SRC_W1, SRC_R} srcT;

    srcT              rrPtr;
    logic [CNT_W-1:0] occupancy;
    logic [RD_LAT-1:0] rdPipe;
    logic             isFull;
    logic             isEmpty;
    logic             eligW0;
    logic             eligW1;
    logic             eligR;
    logic             grantW0;
    logic             grantW1;
    logic             grantR;
    logic [BITS-1:0]  writeWord;

    assign isFull  = (occupancy == CNT_W'(DEPTH));
    assign isEmpty = (occupancy == '0);
    assign eligW0  = bus.wr0_valid & ~isFull;
    assign eligW1  = bus.wr1_valid & ~isFull;
    assign eligR   = bus.rd_req & ~isEmpty;

    assign bus.count     = occupancy;
    assign bus.full      = isFull;
    assign bus.empty     = isEmpty;
    assign bus.wr0_ready = grantW0;
    assign bus.wr1_ready = grantW1;
    assign bus.rd_ack    = grantR;
    assign writeWord     = grantW1 ? bus.wr1_data : bus.wr0_data;

    // Grant the first eligible source, scanning the ring from the current round-robin pointer.
    always_comb begin
        grantW0 = 1'b0;
        grantW1 = 1'b0;
        grantR  = 1'b0;
        case (rrPtr)
            SRC_W0: begin
                if (eligW0)      grantW0 = 1'b1;
                else if (eligW1) grantW1 = 1'b1;
                else if (eligR)  grantR  = 1'b1;
            end
            SRC_W1: begin
                if (eligW1)      grantW1 = 1'b1;
                else if (eligR)  grantR  = 1'b1;
                else if (eligW0) grantW0 = 1'b1;
            end
            default: begin
                if (eligR)       grantR  = 1'b1;
                else if (eligW0) grantW0 = 1'b1;
                else if (eligW1) grantW1 = 1'b1;
            end
        endcase
    end

    // The read pipe carries one flag per granted read. Its output lines up with the cycle
    // in which the SRAM word is presented, so back-to-back reads return back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr          <= SRC_W0;
            occupancy      <= '0;
            rdPipe         <= '0;
            bus.fifo_wr    <= 1'b0;
            bus.fifo_rd    <= 1'b0;
            bus.fifo_wdata <= '0;
            bus.rd_valid   <= 1'b0;
            bus.rd_data    <= '0;
        end else begin
            bus.fifo_wr <= grantW0 | grantW1;
            bus.fifo_rd <= grantR;
            if (grantW0 | grantW1) begin
                bus.fifo_wdata <= writeWord;
                occupancy      <= occupancy + 1'b1;
            end else if (grantR) begin
                occupancy      <= occupancy - 1'b1;
            end

            if (grantW0)      rrPtr <= SRC_W1;
            else if (grantW1) rrPtr <= SRC_R;
            else if (grantR)  rrPtr <= SRC_W0;

            rdPipe[0] <= grantR;
            for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
            bus.rd_valid <= rdPipe[RD_LAT-1];
            if (rdPipe[RD_LAT-1]) bus.rd_data <= bus.fifo_rdata;
        end
    end
endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Self-checking bench for sram_fifo_arbiter: directed scenarios plus randomized traffic.
// The bench compares every cycle against a queue-based reference model and drives a simple SRAM FIFO model.
module tb_sram_fifo_arbiter;
    localparam int BITS   = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int RD_LAT = 2;

    typedef struct {
        int              due;
        logic [BITS-1:0] data;
    } retT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: arbitration ring position, stored words, and outstanding returns.
    int              mCount;
    int              mPtr;
    logic [BITS-1:0] mData[$];
    retT             mRet[$];
    logic            expWr;
    logic            expRd;
    logic            expRdValid;
    logic [BITS-1:0] expWdata;
    logic [BITS-1:0] expRdData;

    logic [BITS-1:0] sramQ[$];

    always #5 clk = ~clk;

    sram_fifo_arbiter_if #(.BITS(BITS), .CNT_W(CNT_W)) bus ();

    sram_fifo_arbiter #(
        .BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // SRAM FIFO behaviour: the read word is presented in the cycle after the strobe is sampled. Otherwise the data is random.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sramQ.delete();
            bus.fifo_rdata <= '0;
        end else begin
            if (bus.fifo_wr) sramQ.push_back(bus.fifo_wdata);
            if (bus.fifo_rd && sramQ.size() > 0) bus.fifo_rdata <= sramQ.pop_front();
            else bus.fifo_rdata <= BITS'($urandom);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        mCount = 0;
        mPtr = 0;
        mData.delete();
        mRet.delete();
        expWr = 1'b0;
        expRd = 1'b0;
        expRdValid = 1'b0;
        expWdata = '0;
        expRdData = '0;
    endtask

    task automatic driveInputs(input logic w0v, input logic [BITS-1:0] w0d,
                               input logic w1v, input logic [BITS-1:0] w1d, input logic rr);
        bus.wr0_valid = w0v;
        bus.wr0_data  = w0d;
        bus.wr1_valid = w1v;
        bus.wr1_data  = w1d;
        bus.rd_req    = rr;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        driveInputs(1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("rst_count", bus.count, 0);
        checkOutput("rst_empty", bus.empty, 1);
        checkOutput("rst_full", bus.full, 0);
        checkOutput("rst_fifo_rd", bus.fifo_rd, 0);
        checkOutput("rst_fifo_wr", bus.fifo_wr, 0);
        checkOutput("rst_fifo_wdata", bus.fifo_wdata, 0);
        checkOutput("rst_rd_valid", bus.rd_valid, 0);
        checkOutput("rst_rd_data", bus.rd_data, 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grants, then advance the model.
    task automatic applyStimulus(input logic w0v, input logic [BITS-1:0] w0d,
                                 input logic w1v, input logic [BITS-1:0] w1d, input logic rr);
        logic elig[3];
        int   g;
        int   src;
        @(negedge clk);
        expRdValid = (mRet.size() > 0) && (mRet[0].due == cyc);
        if (expRdValid) begin
            expRdData = mRet[0].data;
            void'(mRet.pop_front());
        end
        checkOutput("count", bus.count, mCount);
        checkOutput("full", bus.full, mCount == DEPTH);
        checkOutput("empty", bus.empty, mCount == 0);
        checkOutput("fifo_wr", bus.fifo_wr, expWr);
        checkOutput("fifo_rd", bus.fifo_rd, expRd);
        checkOutput("fifo_wdata", bus.fifo_wdata, expWdata);
        checkOutput("rd_valid", bus.rd_valid, expRdValid);
        checkOutput("rd_data", bus.rd_data, expRdData);

        driveInputs(w0v, w0d, w1v, w1d, rr);
        #1;
        elig[0] = w0v && (mCount < DEPTH);
        elig[1] = w1v && (mCount < DEPTH);
        elig[2] = rr && (mCount > 0);
        g = -1;
        for (int k = 0; k < 3; k++) begin
            src = (mPtr + k) % 3;
            if (g < 0 && elig[src]) g = src;
        end
        checkOutput("wr0_ready", bus.wr0_ready, g == 0);
        checkOutput("wr1_ready", bus.wr1_ready, g == 1);
        checkOutput("rd_ack", bus.rd_ack, g == 2);

        @(posedge clk);
        expWr = (g == 0) || (g == 1);
        expRd = (g == 2);
        if (g == 0) begin
            expWdata = w0d;
            mData.push_back(w0d);
            mCount++;
        end else if (g == 1) begin
            expWdata = w1d;
            mData.push_back(w1d);
            mCount++;
        end else if (g == 2) begin
            mRet.push_back('{cyc + 1 + RD_LAT, mData.pop_front()});
            mCount--;
        end
        if (g >= 0) mPtr = (g + 1) % 3;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic readCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [BITS-1:0] d0;
        logic [BITS-1:0] d1;
        driveInputs(1'b0, '0, 1'b0, '0, 1'b0);
        modelReset();
        applyReset();

        // Three writes from requester 0, then let the strobes settle.
        applyStimulus(1'b1, 8'h11, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, '0, 1'b0);
        idleCycles(2);
        readCycles(4);
        idleCycles(RD_LAT + 1);

        // Both writers contend from empty until the FIFO fills.
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, BITS'(8'h40 + i), 1'b1, BITS'(8'h80 + i), 1'b0);

        // Full FIFO with every source requesting.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, BITS'(8'hC0 + i), 1'b1, BITS'(8'hE0 + i), 1'b1);

        // Drain, then a single write followed immediately by a read.
        readCycles(DEPTH + 2);
        idleCycles(RD_LAT + 1);
        applyStimulus(1'b1, 8'hA5, 1'b0, '0, 1'b1);
        readCycles(2);
        idleCycles(RD_LAT + 2);

        // Reads while empty must be ignored.
        readCycles(3);

        // Two reads in flight when reset hits.
        applyStimulus(1'b1, 8'h01, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 8'h02, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0, '0, 1'b0);
        readCycles(2);
        applyReset();
        applyStimulus(1'b1, 8'h5A, 1'b1, 8'h6B, 1'b1);
        applyStimulus(1'b1, 8'h5C, 1'b1, 8'h6D, 1'b1);
        idleCycles(RD_LAT + 2);

        // Randomized traffic in write-heavy, balanced and read-heavy phases, with occasional resets.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 200; i++) begin
                d0 = BITS'($urandom);
                d1 = BITS'($urandom);
                applyStimulus($urandom_range(0, 99) < 70 - 25 * ph, d0,
                              $urandom_range(0, 99) < 60 - 20 * ph, d1,
                              $urandom_range(0, 99) < 30 + 30 * ph);
                if ($urandom_range(0, 149) == 0) applyReset();
            end
        end
        readCycles(DEPTH + 2);
        idleCycles(RD_LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
